// File: rtl/ryuki_datatypes.sv
// Shared trace datatypes: tracker element layout plus the arbiter's state and source ids.
package ryuki_datatypes;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] result;
    } trace_output;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_REQ  = 1'b1
    } arb_state_e;

    typedef enum logic {
        SRC_EX  = 1'b0,
        SRC_MEM = 1'b1
    } trace_src_e;

endpackage

// File: rtl/trace_fifo.sv
// Small per-source FIFO of trace elements; head is the oldest entry, valid when not empty.
module trace_fifo
    import ryuki_datatypes::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  trace_output push_data,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output trace_output head
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    trace_output mem_q [FIFO_DEPTH];
    logic [PW:0] wr_ptr_q;
    logic [PW:0] rd_ptr_q;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/trace_store_arbiter.sv
// Merges EX and memory-stage trace elements into one linear trace memory, round-robin,
// one write per request/grant handshake, stopping once TRACE_DEPTH slots are written.
module trace_store_arbiter
    import ryuki_datatypes::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TRACE_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_data_ready,
    input  trace_output           ex_data_i,
    input  logic                  mem_data_ready,
    input  trace_output           mem_data_i,
    output logic                  store_req_o,
    output logic [ADDR_WIDTH-1:0] store_addr_o,
    output trace_output           store_data_o,
    input  logic                  store_gnt_i,
    output logic                  buffer_full_o,
    output logic [15:0]           dropped_count_o
);

    localparam int unsigned PTR_W = $clog2(TRACE_DEPTH + 1);

    arb_state_e  state_q;
    trace_src_e  sel_q;
    trace_src_e  last_grant_q;
    trace_src_e  pick;
    logic [PTR_W-1:0] wr_ptr_q;
    trace_output data_q;
    logic [15:0] dropped_q;

    logic        ex_full, ex_empty, mem_full, mem_empty;
    trace_output ex_head, mem_head;
    logic        grant, pop_ex, pop_mem, drop_ex, drop_mem, any_pending;
    logic [16:0] drop_sum;

    assign grant   = (state_q == ARB_REQ) && store_gnt_i;
    assign pop_ex  = grant && (sel_q == SRC_EX);
    assign pop_mem = grant && (sel_q == SRC_MEM);
    // Fullness is judged before any same-cycle pop, so a pop never admits a push.
    assign drop_ex  = ex_data_ready && ex_full;
    assign drop_mem = mem_data_ready && mem_full;
    assign drop_sum = {1'b0, dropped_q} + 17'(drop_ex) + 17'(drop_mem);
    assign any_pending = !ex_empty || !mem_empty;

    always_comb begin
        pick = SRC_EX;
        if (!ex_empty && !mem_empty) begin
            pick = (last_grant_q == SRC_MEM) ? SRC_EX : SRC_MEM;
        end else if (ex_empty) begin
            pick = SRC_MEM;
        end
    end

    trace_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_ex_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ex_data_ready),
        .push_data (ex_data_i),
        .pop       (pop_ex),
        .full      (ex_full),
        .empty     (ex_empty),
        .head      (ex_head)
    );

    trace_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_mem_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (mem_data_ready),
        .push_data (mem_data_i),
        .pop       (pop_mem),
        .full      (mem_full),
        .empty     (mem_empty),
        .head      (mem_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            sel_q        <= SRC_EX;
            last_grant_q <= SRC_MEM;
            wr_ptr_q     <= '0;
            data_q       <= '0;
            dropped_q    <= '0;
        end else begin
            dropped_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            case (state_q)
                ARB_IDLE: begin
                    if (!buffer_full_o && any_pending) begin
                        sel_q   <= pick;
                        data_q  <= (pick == SRC_EX) ? ex_head : mem_head;
                        state_q <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (store_gnt_i) begin
                        wr_ptr_q     <= wr_ptr_q + 1'b1;
                        last_grant_q <= sel_q;
                        state_q      <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // The slot index only moves on a grant, so it is stable for the whole request.
    assign store_req_o     = (state_q == ARB_REQ);
    assign store_addr_o    = ADDR_WIDTH'(wr_ptr_q);
    assign store_data_o    = data_q;
    assign buffer_full_o   = (wr_ptr_q == PTR_W'(TRACE_DEPTH));
    assign dropped_count_o = dropped_q;

endmodule

// File: tb/tb_trace_store_arbiter.sv
// Scoreboard bench for trace_store_arbiter, built with a 4-slot trace memory.
module tb_trace_store_arbiter;
    import ryuki_datatypes::*;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_data_ready, mem_data_ready;
    trace_output   ex_data_i, mem_data_i;
    logic          store_req_o;
    logic [AW-1:0] store_addr_o;
    trace_output   store_data_o;
    logic          store_gnt_i;
    logic          buffer_full_o;
    logic [15:0]   dropped_count_o;

    int n_cmp = 0;
    int n_bad = 0;
    trace_output exp_q[$];
    int exp_addr = 0;
    int wr_seen = 0;
    trace_output mon_t;

    trace_store_arbiter #(
        .ADDR_WIDTH  (AW),
        .FIFO_DEPTH  (4),
        .TRACE_DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_data_ready   (ex_data_ready),
        .ex_data_i       (ex_data_i),
        .mem_data_ready  (mem_data_ready),
        .mem_data_i      (mem_data_i),
        .store_req_o     (store_req_o),
        .store_addr_o    (store_addr_o),
        .store_data_o    (store_data_o),
        .store_gnt_i     (store_gnt_i),
        .buffer_full_o   (buffer_full_o),
        .dropped_count_o (dropped_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic trace_output mk(input int src, input int n);
        trace_output t;
        t.pc     = 32'h1000 + 32'(src * 256 + n * 4);
        t.instr  = 32'hA500_0000 | 32'(src * 16 + n);
        t.result = 32'hC0DE_0000 ^ 32'(src * 4096 + n * 7);
        return t;
    endfunction

    // A write is accepted at the posedge following a negedge that sees req && gnt.
    always @(negedge clk) begin
        if (!rst && store_req_o && store_gnt_i) begin
            wr_seen++;
            check("full_before_write", buffer_full_o, 1'b0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1'b1, 1'b0);
            end else begin
                mon_t = exp_q.pop_front();
                check("wr_data", store_data_o, mon_t);
                check("wr_addr", store_addr_o, exp_addr);
            end
            exp_addr++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit ex, input trace_output de, input bit mem, input trace_output dm);
        ex_data_ready  = ex;
        ex_data_i      = de;
        mem_data_ready = mem;
        mem_data_i     = dm;
        tick();
        ex_data_ready  = 1'b0;
        mem_data_ready = 1'b0;
    endtask

    task automatic do_reset(input logic gnt);
        store_gnt_i    = gnt;
        rst            = 1'b1;
        ex_data_ready  = 1'b0;
        mem_data_ready = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
        exp_q.delete();
        exp_addr = 0;
        wr_seen  = 0;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        check(tag, exp_q.size(), 0);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_hits;
        ex_data_i  = '0;
        mem_data_i = '0;

        // Reset state
        do_reset(1'b1);
        check("rst_req", store_req_o, 1'b0);
        check("rst_addr", store_addr_o, 0);
        check("rst_data", store_data_o, 0);
        check("rst_full", buffer_full_o, 1'b0);
        check("rst_drop", dropped_count_o, 0);

        // Single EX element, gnt tied high: request in cycle 2
        exp_q.push_back(mk(1, 0));
        pulse(1'b1, mk(1, 0), 1'b0, '0);
        check("lat_c1_req", store_req_o, 1'b0);
        tick();
        check("lat_c2_req", store_req_o, 1'b1);
        check("lat_c2_addr", store_addr_o, 0);
        check("lat_c2_data", store_data_o, mk(1, 0));
        tick();
        check("lat_c3_req", store_req_o, 1'b0);
        check("lat_c3_addr", store_addr_o, 1);
        check("lat_c3_hold", store_data_o, mk(1, 0));
        check("lat_cnt", wr_seen, 1);

        // Simultaneous EX and MEM: EX first on a fresh tie
        do_reset(1'b1);
        exp_q.push_back(mk(1, 1));
        exp_q.push_back(mk(2, 1));
        pulse(1'b1, mk(1, 1), 1'b1, mk(2, 1));
        wait_drain("pair_drain");
        check("pair_cnt", wr_seen, 2);
        check("pair_addr", store_addr_o, 2);

        // gnt held low: outputs stable, then exactly one pop
        do_reset(1'b0);
        exp_q.push_back(mk(1, 2));
        exp_q.push_back(mk(1, 3));
        pulse(1'b1, mk(1, 2), 1'b0, '0);
        pulse(1'b1, mk(1, 3), 1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            check("hold_req", store_req_o, 1'b1);
            check("hold_addr", store_addr_o, 0);
            check("hold_data", store_data_o, mk(1, 2));
            tick();
        end
        store_gnt_i = 1'b1;
        tick();
        store_gnt_i = 1'b0;
        tick();
        tick();
        check("one_pop_cnt", wr_seen, 1);
        check("one_pop_req", store_req_o, 1'b1);
        check("one_pop_addr", store_addr_o, 1);
        check("one_pop_data", store_data_o, mk(1, 3));
        store_gnt_i = 1'b1;
        wait_drain("hold_drain");

        // Overflow: 6 EX pulses into a 4-entry FIFO with gnt low
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back(mk(1, 8 + i));
            pulse(1'b1, mk(1, 8 + i), 1'b0, '0);
        end
        tick();
        check("ovf_drop", dropped_count_o, 2);
        check("ovf_req", store_req_o, 1'b1);
        store_gnt_i = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_cnt", wr_seen, 4);
        check("ovf_full", buffer_full_o, 1'b1);
        check("ovf_drop_after", dropped_count_o, 2);

        // Both FIFOs full: drops add 2, drain alternates EX/MEM
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            pulse(1'b1, mk(1, 16 + i), 1'b1, mk(2, 16 + i));
        end
        exp_q.push_back(mk(1, 16));
        exp_q.push_back(mk(2, 16));
        exp_q.push_back(mk(1, 17));
        exp_q.push_back(mk(2, 17));
        tick();
        check("both_drop", dropped_count_o, 2);
        store_gnt_i = 1'b1;
        wait_drain("both_drain");
        check("both_cnt", wr_seen, 4);

        // TRACE_DEPTH reached: 5th element never requested
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(mk(2, 24 + i));
            pulse(1'b0, '0, 1'b1, mk(2, 24 + i));
            tick();
            tick();
        end
        req_hits = 0;
        for (int i = 0; i < 10; i++) begin
            if (store_req_o) req_hits++;
            tick();
        end
        check("depth_cnt", wr_seen, 4);
        check("depth_full", buffer_full_o, 1'b1);
        check("depth_no_req", req_hits, 0);
        check("depth_addr", store_addr_o, 4);
        check("depth_pending", exp_q.size(), 0);

        // Reset while in REQ abandons the write; pulses during reset discarded
        do_reset(1'b0);
        pulse(1'b1, mk(1, 30), 1'b0, '0);
        tick();
        check("rr_in_req", store_req_o, 1'b1);
        rst = 1'b1;
        pulse(1'b1, mk(1, 31), 1'b1, mk(2, 31));
        check("rr_req", store_req_o, 1'b0);
        check("rr_addr", store_addr_o, 0);
        check("rr_data", store_data_o, 0);
        check("rr_full", buffer_full_o, 1'b0);
        check("rr_drop", dropped_count_o, 0);
        rst = 1'b0;
        exp_q.delete();
        exp_addr = 0;
        wr_seen  = 0;
        req_hits = 0;
        for (int i = 0; i < 4; i++) begin
            if (store_req_o) req_hits++;
            tick();
        end
        check("rr_idle", req_hits, 0);
        store_gnt_i = 1'b1;
        exp_q.push_back(mk(1, 32));
        pulse(1'b1, mk(1, 32), 1'b0, '0);
        wait_drain("rr_drain");
        check("rr_cnt", wr_seen, 1);
        check("rr_addr_after", store_addr_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
